// File: rtl/interp_pkg.sv
// Shared definitions for the block sequencer: FSM state encoding and
// default frame geometry.
package interp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam int IDX_W_DEF      = 4;
  localparam int NUM_BLOCKS_DEF = 16;
  localparam int SUB_W_DEF      = 3;
  localparam int NUM_SUB_DEF    = 8;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MOD counter with synchronous clear, load and enable; wrap_o flags
// the terminal count so the parent can chain counters.
module wrap_counter #(
  parameter int W   = 4,
  parameter int MOD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] MAX = W'(MOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: next-state logic assigns cnt_d a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == MAX) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = (cnt_q == MAX);

endmodule

// File: rtl/block_sequencer.sv
// Walks a frame of NUM_BLOCKS blocks, each NUM_SUB sub-steps long, advancing
// on STEP and pulsing DONE once after the last sub-step of the last block.
module block_sequencer
  import interp_pkg::*;
#(
  parameter int IDX_W      = IDX_W_DEF,
  parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
  parameter int SUB_W      = SUB_W_DEF,
  parameter int NUM_SUB    = NUM_SUB_DEF
) (
  input  logic             CLK,
  input  logic             RST_ASYNC_N,
  input  logic             START,
  input  logic             STEP,
  input  logic             ABORT,
  input  logic             LOAD_EN,
  input  logic [IDX_W-1:0] LOAD_VALUE,
  output logic [IDX_W-1:0] BLOCK_IDX,
  output logic [SUB_W-1:0] SUB_IDX,
  output logic             BUSY,
  output logic             LAST,
  output logic             DONE
);

  // One extra bit so NUM_BLOCKS == 2^IDX_W is representable.
  localparam logic [IDX_W:0] BLK_LIMIT = (IDX_W + 1)'(NUM_BLOCKS);

  state_e state_q;
  logic   done_q;

  logic in_idle, in_run;
  logic load_ok, advance, last_w;
  logic sub_wrap, blk_wrap;

  assign in_idle = (state_q == ST_IDLE);
  assign in_run  = (state_q == ST_RUN);
  assign load_ok = in_idle && LOAD_EN && ({1'b0, LOAD_VALUE} < BLK_LIMIT);
  // ABORT outranks STEP, so a colliding STEP must not move either counter.
  assign advance = in_run && STEP && !ABORT;
  assign last_w  = in_run && blk_wrap && sub_wrap;

  wrap_counter #(.W(SUB_W), .MOD(NUM_SUB)) u_sub_cnt (
    .clk       (CLK),
    .rst_n     (RST_ASYNC_N),
    .clr_i     ((in_idle && START) || (in_run && ABORT)),
    .load_i    (1'b0),
    .load_val_i('0),
    .en_i      (advance),
    .cnt_o     (SUB_IDX),
    .wrap_o    (sub_wrap)
  );

  wrap_counter #(.W(IDX_W), .MOD(NUM_BLOCKS)) u_blk_cnt (
    .clk       (CLK),
    .rst_n     (RST_ASYNC_N),
    .clr_i     (1'b0),
    .load_i    (load_ok),
    .load_val_i(LOAD_VALUE),
    .en_i      (advance && sub_wrap),
    .cnt_o     (BLOCK_IDX),
    .wrap_o    (blk_wrap)
  );

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (ABORT) begin
            state_q <= ST_IDLE;
          end else if (STEP && last_w) begin
            state_q <= ST_FINISH;
            done_q  <= 1'b1;
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign BUSY = in_run;
  assign LAST = last_w;
  assign DONE = done_q;

endmodule

// File: tb/tb_block_sequencer.sv
// Directed bench for block_sequencer: 4 blocks x 2 sub-steps main instance,
// plus a 2 x 1 instance for the single-sub-step case.
module tb_block_sequencer;

  localparam int IDX_W = 4;
  localparam int NB    = 4;
  localparam int SUB_W = 3;
  localparam int NS    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0, step = 1'b0, abort = 1'b0, load_en = 1'b0;
  logic [IDX_W-1:0] load_value = '0;
  logic [IDX_W-1:0] blk_idx;
  logic [SUB_W-1:0] sub_idx;
  logic             busy, last, done;

  logic start2 = 1'b0, step2 = 1'b0;
  logic blk2, sub2, busy2, last2, done2;

  int checks = 0;
  int errors = 0;

  block_sequencer #(.IDX_W(IDX_W), .NUM_BLOCKS(NB), .SUB_W(SUB_W), .NUM_SUB(NS)) dut (
    .CLK(clk), .RST_ASYNC_N(rst_n), .START(start), .STEP(step), .ABORT(abort),
    .LOAD_EN(load_en), .LOAD_VALUE(load_value), .BLOCK_IDX(blk_idx),
    .SUB_IDX(sub_idx), .BUSY(busy), .LAST(last), .DONE(done)
  );

  block_sequencer #(.IDX_W(1), .NUM_BLOCKS(2), .SUB_W(1), .NUM_SUB(1)) dut_ns1 (
    .CLK(clk), .RST_ASYNC_N(rst_n), .START(start2), .STEP(step2), .ABORT(1'b0),
    .LOAD_EN(1'b0), .LOAD_VALUE(1'b0), .BLOCK_IDX(blk2),
    .SUB_IDX(sub2), .BUSY(busy2), .LAST(last2), .DONE(done2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset asserted between edges.
    #2 rst_n = 1'b0;
    #10;
    check("rst_blk", 32'(blk_idx), 0);
    check("rst_sub", 32'(sub_idx), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_last", 32'(last), 0);
    check("rst_done", 32'(done), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Full frame from block 0.
    start = 1'b1; tick(); start = 1'b0;
    check("t1_busy", 32'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_blk%0d", i), 32'(blk_idx), 32'(i / 2));
      check($sformatf("t1_sub%0d", i), 32'(sub_idx), 32'(i % 2));
      check($sformatf("t1_last%0d", i), 32'(last), 32'(i == 7));
      check($sformatf("t1_done%0d", i), 32'(done), 0);
      step = 1'b1; tick(); step = 1'b0;
    end
    check("t1_done_pulse", 32'(done), 1);
    check("t1_fin_busy", 32'(busy), 0);
    check("t1_fin_blk", 32'(blk_idx), 0);
    check("t1_fin_sub", 32'(sub_idx), 0);
    tick();
    check("t1_done_low", 32'(done), 0);
    check("t1_idle_busy", 32'(busy), 0);

    // Load + start together, run from block 2.
    load_en = 1'b1; load_value = 4'd2; start = 1'b1; tick();
    load_en = 1'b0; start = 1'b0;
    check("t2_blk", 32'(blk_idx), 2);
    check("t2_sub", 32'(sub_idx), 0);
    check("t2_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_last%0d", i), 32'(last), 32'(i == 3));
      step = 1'b1; tick(); step = 1'b0;
      if (i < 3) check($sformatf("t2_done%0d", i), 32'(done), 0);
    end
    check("t2_done_pulse", 32'(done), 1);
    check("t2_fin_blk", 32'(blk_idx), 0);
    tick();
    check("t2_idle_busy", 32'(busy), 0);

    // Out-of-range load ignored, in-range load taken.
    load_value = 4'd5; load_en = 1'b1; tick(); load_en = 1'b0;
    check("bad_load_blk", 32'(blk_idx), 0);
    load_value = 4'd1; load_en = 1'b1; tick(); load_en = 1'b0;
    check("good_load_blk", 32'(blk_idx), 1);
    check("good_load_busy", 32'(busy), 0);

    // STEP/ABORT ignored in IDLE.
    step = 1'b1; abort = 1'b1; tick(); step = 1'b0; abort = 1'b0;
    check("idle_step_blk", 32'(blk_idx), 1);
    check("idle_step_sub", 32'(sub_idx), 0);
    check("idle_step_busy", 32'(busy), 0);

    // ABORT beats STEP at block 1 sub 1.
    start = 1'b1; tick(); start = 1'b0;
    step = 1'b1; tick(); step = 1'b0;
    check("ab_pre_blk", 32'(blk_idx), 1);
    check("ab_pre_sub", 32'(sub_idx), 1);
    abort = 1'b1; step = 1'b1; tick(); abort = 1'b0; step = 1'b0;
    check("ab_busy", 32'(busy), 0);
    check("ab_blk", 32'(blk_idx), 1);
    check("ab_sub", 32'(sub_idx), 0);
    check("ab_done", 32'(done), 0);
    tick();
    check("ab_done_next", 32'(done), 0);

    // START/LOAD_EN ignored in RUN; inputs ignored in FINISH.
    start = 1'b1; tick();
    load_en = 1'b1; load_value = 4'd3; tick();
    start = 1'b0; load_en = 1'b0;
    check("run_ign_blk", 32'(blk_idx), 1);
    check("run_ign_sub", 32'(sub_idx), 0);
    check("run_ign_busy", 32'(busy), 1);
    step = 1'b1; repeat (6) tick(); step = 1'b0;
    check("fin_done", 32'(done), 1);
    step = 1'b1; start = 1'b1; load_en = 1'b1; load_value = 4'd2; tick();
    step = 1'b0; start = 1'b0; load_en = 1'b0;
    check("fin_ign_busy", 32'(busy), 0);
    check("fin_ign_done", 32'(done), 0);
    check("fin_ign_blk", 32'(blk_idx), 0);
    check("fin_ign_sub", 32'(sub_idx), 0);
    tick();
    check("fin_ign_busy2", 32'(busy), 0);

    // Asynchronous reset mid-RUN at block 3.
    start = 1'b1; tick(); start = 1'b0;
    step = 1'b1; repeat (6) tick(); step = 1'b0;
    check("mr_pre_blk", 32'(blk_idx), 3);
    check("mr_pre_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_blk", 32'(blk_idx), 0);
    check("mr_sub", 32'(sub_idx), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_last", 32'(last), 0);
    check("mr_done", 32'(done), 0);
    #1 rst_n = 1'b1;
    tick();
    check("mr_post_busy", 32'(busy), 0);
    check("mr_post_done", 32'(done), 0);
    start = 1'b1; tick(); start = 1'b0;
    check("mr_start_busy", 32'(busy), 1);
    check("mr_start_blk", 32'(blk_idx), 0);

    // NUM_SUB = 1: every STEP advances the block.
    start2 = 1'b1; tick(); start2 = 1'b0;
    check("ns1_blk0", 32'(blk2), 0);
    check("ns1_last0", 32'(last2), 0);
    step2 = 1'b1; tick(); step2 = 1'b0;
    check("ns1_blk1", 32'(blk2), 1);
    check("ns1_sub1", 32'(sub2), 0);
    check("ns1_last1", 32'(last2), 1);
    step2 = 1'b1; tick(); step2 = 1'b0;
    check("ns1_done", 32'(done2), 1);
    check("ns1_fin_blk", 32'(blk2), 0);
    check("ns1_fin_busy", 32'(busy2), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_sequencer.md
BLOCK_SEQUENCER -- requirements
Module: block_sequencer

Interface
Parameters:
REQ-001 SHALL have parameter IDX_W, default 4, width of block index.
REQ-002 SHALL have parameter NUM_BLOCKS, default 16, blocks per frame (2..2^IDX_W).
REQ-003 SHALL have parameter SUB_W, default 3, width of sub-step index.
REQ-004 SHALL have parameter NUM_SUB, default 8, sub-steps per block (1..2^SUB_W).
Ports:
REQ-005 SHALL have CLK  input  1  clock, all state on rising edge.
REQ-006 SHALL have RST_ASYNC_N  input  1  reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have START  input  1  begin a frame sequence.
REQ-008 SHALL have STEP  input  1  datapath finished one sub-step.
REQ-009 SHALL have ABORT  input  1  cancel running sequence.
REQ-010 SHALL have LOAD_EN  input  1  preset block index.
REQ-011 SHALL have LOAD_VALUE  input  IDX_W  preset value.
REQ-012 SHALL have BLOCK_IDX  output  IDX_W  current block, registered.
REQ-013 SHALL have SUB_IDX  output  SUB_W  current sub-step, registered.
REQ-014 SHALL have BUSY  output  1  high in RUN.
REQ-015 SHALL have LAST  output  1  combinational: RUN and BLOCK_IDX=NUM_BLOCKS-1 and SUB_IDX=NUM_SUB-1.
REQ-016 SHALL have DONE  output  1  registered one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, FINISH.
REQ-018 IDLE: LOAD_EN with LOAD_VALUE<NUM_BLOCKS SHALL write BLOCK_IDX next edge; LOAD_VALUE>=NUM_BLOCKS SHALL be ignored.
REQ-019 IDLE: START SHALL go to RUN, SUB_IDX<=0, BLOCK_IDX kept; START with a valid load in the same cycle SHALL both load and start (run from loaded value).
REQ-020 RUN: STEP with SUB_IDX<NUM_SUB-1 SHALL increment SUB_IDX only.
REQ-021 RUN: STEP with SUB_IDX=NUM_SUB-1 SHALL set SUB_IDX<=0 and increment BLOCK_IDX.
REQ-022 RUN: STEP while LAST SHALL wrap BLOCK_IDX<=0, SUB_IDX<=0, go to FINISH.
REQ-023 FINISH SHALL assert DONE exactly one cycle, then go to IDLE unconditionally; START/STEP/LOAD_EN ignored in FINISH.
REQ-024 ABORT in RUN SHALL take priority over STEP: go to IDLE, SUB_IDX<=0, BLOCK_IDX held, no DONE.
REQ-025 START, LOAD_EN SHALL be ignored in RUN; STEP, ABORT ignored in IDLE.
REQ-026 Increments SHALL never produce values >=NUM_BLOCKS or >=NUM_SUB; NUM_SUB=1 SHALL advance BLOCK_IDX on every STEP.
REQ-027 Latency: STEP at edge n SHALL be reflected in outputs after edge n; DONE high the cycle after the final STEP edge.

Reset
REQ-028 RST_ASYNC_N low SHALL immediately force IDLE, BLOCK_IDX=0, SUB_IDX=0, BUSY=0, DONE=0, LAST=0, including mid-RUN.
REQ-029 Release SHALL need no further init; first START after release SHALL run from block 0.

Structure
REQ-030 FSM state encodings and default parameter values SHALL live in shared package interp_pkg.
REQ-031 Sub-module wrap_counter (parametrised width/modulus, enable, load, wrap flag) SHALL be instantiated twice: sub-step and block counters.

Verification (NUM_BLOCKS=4, NUM_SUB=2)
REQ-032 Reset, START, 8 STEPs -> SUB_IDX 0,1,0,1..., BLOCK_IDX 0,0,1,1,2,2,3,3; LAST on 8th; DONE one cycle after; back IDLE, BLOCK_IDX=0.
REQ-033 IDLE LOAD_EN=1 LOAD_VALUE=2 with START same cycle, 4 STEPs -> run from block 2, DONE after 4th STEP; LOAD_VALUE=5 -> BLOCK_IDX unchanged.
REQ-034 RUN at block 1 sub 1, ABORT and STEP same cycle -> IDLE, BLOCK_IDX=1, SUB_IDX=0, no DONE.
REQ-035 START and LOAD_EN during RUN, STEP during FINISH -> no effect on indices/state.
REQ-036 RST_ASYNC_N pulsed low between edges mid-RUN at block 3 -> outputs zero immediately, BUSY=0, no DONE.
